nasti_slice: RTL and testbench

//  Parametrised NASTI (AXI4) register slice: one independent FIFO per channel
//  (AW, W, B, AR, R) between a slave-side and master-side nasti_if. Breaks

---
 rtl/nasti_slice_pkg.sv | 49 ++++
 rtl/nasti_slice_chan_fifo.sv | 89 ++++++++
 rtl/nasti_slice.sv | 193 +++++++++++++++++++
 tb/tb_nasti_slice.sv | 529 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nasti_slice_pkg.sv
// Shared definitions for the NASTI register slice: fixed AXI4 field widths and
// helpers that compute the packed payload width of each channel.
package nasti_slice_pkg;

    localparam int unsigned LEN_W    = 8;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned BURST_W  = 2;
    localparam int unsigned LOCK_W   = 1;
    localparam int unsigned CACHE_W  = 4;
    localparam int unsigned PROT_W   = 3;
    localparam int unsigned QOS_W    = 4;
    localparam int unsigned REGION_W = 4;
    localparam int unsigned RESP_W   = 2;

    // id, addr, len, size, burst, lock, cache, prot, qos, region, user
    function automatic int unsigned aw_payload_w(input int unsigned id_w,
                                                 input int unsigned addr_w,
                                                 input int unsigned user_w);
        return id_w + addr_w + LEN_W + SIZE_W + BURST_W + LOCK_W + CACHE_W + PROT_W +
               QOS_W + REGION_W + user_w;
    endfunction

    // AR carries exactly the same field set as AW
    function automatic int unsigned ar_payload_w(input int unsigned id_w,
                                                 input int unsigned addr_w,
                                                 input int unsigned user_w);
        return aw_payload_w(id_w, addr_w, user_w);
    endfunction

    // data, strb, last, user
    function automatic int unsigned w_payload_w(input int unsigned data_w,
                                                input int unsigned user_w);
        return data_w + data_w / 8 + 1 + user_w;
    endfunction

    // id, resp, user
    function automatic int unsigned b_payload_w(input int unsigned id_w,
                                                input int unsigned user_w);
        return id_w + RESP_W + user_w;
    endfunction

    // id, data, resp, last, user
    function automatic int unsigned r_payload_w(input int unsigned id_w,
                                                input int unsigned data_w,
                                                input int unsigned user_w);
        return id_w + data_w + RESP_W + 1 + user_w;
    endfunction

endpackage

// File: rtl/nasti_slice_chan_fifo.sv
// Generic valid/ready channel FIFO used once per NASTI channel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload (head entry)
//   empty               : no stored beats (always 1 in bypass)
// DEPTH = 0 wires the channel straight through. DEPTH > 0 is a circular buffer
// whose in_ready is a register, so no combinational path runs from out_ready
// back to in_ready.
module nasti_slice_chan_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int          DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    if (DEPTH < 0) begin : g_bad_depth
        $error("nasti_slice_chan_fifo: DEPTH must be >= 0");
    end

    if (DEPTH == 0) begin : g_bypass
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign empty     = 1'b1;

        logic unused_ctl;
        assign unused_ctl = clk ^ rst_n;
    end else begin : g_fifo
        localparam int CNT_W = $clog2(DEPTH + 1);
        localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
        localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

        // Sized to the full pointer range so every pointer value indexes legally;
        // entries at or beyond DEPTH are never written.
        logic [WIDTH-1:0] mem [1 << PTR_W];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             rdy_q;
        logic             push;
        logic             pop;

        assign push      = in_valid & rdy_q;
        assign pop       = out_valid & out_ready;
        assign in_ready  = rdy_q;
        assign out_valid = (cnt_q != '0);
        assign out_data  = mem[rd_ptr_q];
        assign empty     = (cnt_q == '0);

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
        end

        // rdy_q stays low through reset and rises on the first clock after release.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                rdy_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                rdy_q    <= (cnt_d != FULL_CNT);
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/nasti_slice.sv
// NASTI (AXI4) register slice: one independent FIFO per channel between the
// slave-side (s_*) and master-side (m_*) ports.
//   clk, rst_n : clock, asynchronous active-low reset
//   s_aw/s_w/s_ar in, s_b/s_r out : upstream (interconnect) side
//   m_aw/m_w/m_ar out, m_b/m_r in : downstream (controller) side
//   idle       : every channel FIFO empty
// Each *_DEPTH: 0 = combinational pass-through, 1 = half rate, >=2 full rate.
module nasti_slice
    import nasti_slice_pkg::*;
#(
    parameter int ID_WIDTH   = 9,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int AW_DEPTH   = 2,
    parameter int W_DEPTH    = 2,
    parameter int B_DEPTH    = 2,
    parameter int AR_DEPTH   = 2,
    parameter int R_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // slave side
    input  logic                    s_aw_valid,
    output logic                    s_aw_ready,
    input  logic [ID_WIDTH-1:0]     s_aw_id,
    input  logic [ADDR_WIDTH-1:0]   s_aw_addr,
    input  logic [LEN_W-1:0]        s_aw_len,
    input  logic [SIZE_W-1:0]       s_aw_size,
    input  logic [BURST_W-1:0]      s_aw_burst,
    input  logic                    s_aw_lock,
    input  logic [CACHE_W-1:0]      s_aw_cache,
    input  logic [PROT_W-1:0]       s_aw_prot,
    input  logic [QOS_W-1:0]        s_aw_qos,
    input  logic [REGION_W-1:0]     s_aw_region,
    input  logic [USER_WIDTH-1:0]   s_aw_user,
    input  logic                    s_w_valid,
    output logic                    s_w_ready,
    input  logic [DATA_WIDTH-1:0]   s_w_data,
    input  logic [DATA_WIDTH/8-1:0] s_w_strb,
    input  logic                    s_w_last,
    input  logic [USER_WIDTH-1:0]   s_w_user,
    output logic                    s_b_valid,
    input  logic                    s_b_ready,
    output logic [ID_WIDTH-1:0]     s_b_id,
    output logic [RESP_W-1:0]       s_b_resp,
    output logic [USER_WIDTH-1:0]   s_b_user,
    input  logic                    s_ar_valid,
    output logic                    s_ar_ready,
    input  logic [ID_WIDTH-1:0]     s_ar_id,
    input  logic [ADDR_WIDTH-1:0]   s_ar_addr,
    input  logic [LEN_W-1:0]        s_ar_len,
    input  logic [SIZE_W-1:0]       s_ar_size,
    input  logic [BURST_W-1:0]      s_ar_burst,
    input  logic                    s_ar_lock,
    input  logic [CACHE_W-1:0]      s_ar_cache,
    input  logic [PROT_W-1:0]       s_ar_prot,
    input  logic [QOS_W-1:0]        s_ar_qos,
    input  logic [REGION_W-1:0]     s_ar_region,
    input  logic [USER_WIDTH-1:0]   s_ar_user,
    output logic                    s_r_valid,
    input  logic                    s_r_ready,
    output logic [ID_WIDTH-1:0]     s_r_id,
    output logic [DATA_WIDTH-1:0]   s_r_data,
    output logic [RESP_W-1:0]       s_r_resp,
    output logic                    s_r_last,
    output logic [USER_WIDTH-1:0]   s_r_user,
    // master side
    output logic                    m_aw_valid,
    input  logic                    m_aw_ready,
    output logic [ID_WIDTH-1:0]     m_aw_id,
    output logic [ADDR_WIDTH-1:0]   m_aw_addr,
    output logic [LEN_W-1:0]        m_aw_len,
    output logic [SIZE_W-1:0]       m_aw_size,
    output logic [BURST_W-1:0]      m_aw_burst,
    output logic                    m_aw_lock,
    output logic [CACHE_W-1:0]      m_aw_cache,
    output logic [PROT_W-1:0]       m_aw_prot,
    output logic [QOS_W-1:0]        m_aw_qos,
    output logic [REGION_W-1:0]     m_aw_region,
    output logic [USER_WIDTH-1:0]   m_aw_user,
    output logic                    m_w_valid,
    input  logic                    m_w_ready,
    output logic [DATA_WIDTH-1:0]   m_w_data,
    output logic [DATA_WIDTH/8-1:0] m_w_strb,
    output logic                    m_w_last,
    output logic [USER_WIDTH-1:0]   m_w_user,
    input  logic                    m_b_valid,
    output logic                    m_b_ready,
    input  logic [ID_WIDTH-1:0]     m_b_id,
    input  logic [RESP_W-1:0]       m_b_resp,
    input  logic [USER_WIDTH-1:0]   m_b_user,
    output logic                    m_ar_valid,
    input  logic                    m_ar_ready,
    output logic [ID_WIDTH-1:0]     m_ar_id,
    output logic [ADDR_WIDTH-1:0]   m_ar_addr,
    output logic [LEN_W-1:0]        m_ar_len,
    output logic [SIZE_W-1:0]       m_ar_size,
    output logic [BURST_W-1:0]      m_ar_burst,
    output logic                    m_ar_lock,
    output logic [CACHE_W-1:0]      m_ar_cache,
    output logic [PROT_W-1:0]       m_ar_prot,
    output logic [QOS_W-1:0]        m_ar_qos,
    output logic [REGION_W-1:0]     m_ar_region,
    output logic [USER_WIDTH-1:0]   m_ar_user,
    input  logic                    m_r_valid,
    output logic                    m_r_ready,
    input  logic [ID_WIDTH-1:0]     m_r_id,
    input  logic [DATA_WIDTH-1:0]   m_r_data,
    input  logic [RESP_W-1:0]       m_r_resp,
    input  logic                    m_r_last,
    input  logic [USER_WIDTH-1:0]   m_r_user,
    output logic                    idle
);

    if (USER_WIDTH <= 0) begin : g_bad_user
        $error("nasti_slice: USER_WIDTH must be > 0");
    end
    if (ID_WIDTH <= 0 || ADDR_WIDTH <= 0 || DATA_WIDTH <= 0 || DATA_WIDTH % 8 != 0)
    begin : g_bad_width
        $error("nasti_slice: ID/ADDR widths must be > 0, DATA_WIDTH a multiple of 8");
    end

    localparam int unsigned AW_W = aw_payload_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
    localparam int unsigned W_W  = w_payload_w(DATA_WIDTH, USER_WIDTH);
    localparam int unsigned B_W  = b_payload_w(ID_WIDTH, USER_WIDTH);
    localparam int unsigned AR_W = ar_payload_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
    localparam int unsigned R_W  = r_payload_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH);

    logic [AW_W-1:0] aw_in, aw_out;
    logic [W_W-1:0]  w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [AR_W-1:0] ar_in, ar_out;
    logic [R_W-1:0]  r_in, r_out;
    logic            aw_empty, w_empty, b_empty, ar_empty, r_empty;

    assign aw_in = {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock,
                    s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region, s_aw_user};
    assign {m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock,
            m_aw_cache, m_aw_prot, m_aw_qos, m_aw_region, m_aw_user} = aw_out;

    assign w_in = {s_w_data, s_w_strb, s_w_last, s_w_user};
    assign {m_w_data, m_w_strb, m_w_last, m_w_user} = w_out;

    assign b_in = {m_b_id, m_b_resp, m_b_user};
    assign {s_b_id, s_b_resp, s_b_user} = b_out;

    assign ar_in = {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
                    s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user};
    assign {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock,
            m_ar_cache, m_ar_prot, m_ar_qos, m_ar_region, m_ar_user} = ar_out;

    assign r_in = {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user};
    assign {s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user} = r_out;

    nasti_slice_chan_fifo #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_aw_valid), .in_ready(s_aw_ready), .in_data(aw_in),
        .out_valid(m_aw_valid), .out_ready(m_aw_ready), .out_data(aw_out),
        .empty(aw_empty)
    );

    nasti_slice_chan_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_w_valid), .in_ready(s_w_ready), .in_data(w_in),
        .out_valid(m_w_valid), .out_ready(m_w_ready), .out_data(w_out),
        .empty(w_empty)
    );

    nasti_slice_chan_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_b_valid), .in_ready(m_b_ready), .in_data(b_in),
        .out_valid(s_b_valid), .out_ready(s_b_ready), .out_data(b_out),
        .empty(b_empty)
    );

    nasti_slice_chan_fifo #(.WIDTH(AR_W), .DEPTH(AR_DEPTH)) u_ar (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_ar_valid), .in_ready(s_ar_ready), .in_data(ar_in),
        .out_valid(m_ar_valid), .out_ready(m_ar_ready), .out_data(ar_out),
        .empty(ar_empty)
    );

    nasti_slice_chan_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_r_valid), .in_ready(m_r_ready), .in_data(r_in),
        .out_valid(s_r_valid), .out_ready(s_r_ready), .out_data(r_out),
        .empty(r_empty)
    );

    assign idle = aw_empty & w_empty & b_empty & ar_empty & r_empty;

endmodule

// File: tb/tb_nasti_slice.sv
// Self-checking bench for nasti_slice. Channels are handled as an indexed set
// (0=AW, 1=W, 2=B, 3=AR, 4=R): in_* is the producer side, out_* the consumer
// side. The reference model tracks each FIFO as a list of accepted beats.
module tb_nasti_slice;

    localparam int AW_D = 2;
    localparam int W_D  = 2;
    localparam int B_D  = 1;
    localparam int AR_D = 0;
    localparam int R_D  = 4;
    localparam int DEP [5] = '{AW_D, W_D, B_D, AR_D, R_D};
    localparam int PW  [5] = '{71, 74, 12, 71, 77};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  in_valid = '0;
    logic [4:0]  out_ready = '0;
    logic [79:0] in_pl [5];
    logic [4:0]  in_rdy;
    logic [4:0]  out_vld;
    logic [79:0] out_pl [5];
    logic        idle;

    logic        s_aw_valid, s_aw_ready, s_aw_lock, m_aw_valid, m_aw_ready, m_aw_lock;
    logic [8:0]  s_aw_id, m_aw_id;
    logic [31:0] s_aw_addr, m_aw_addr;
    logic [7:0]  s_aw_len, m_aw_len;
    logic [2:0]  s_aw_size, m_aw_size, s_aw_prot, m_aw_prot;
    logic [1:0]  s_aw_burst, m_aw_burst;
    logic [3:0]  s_aw_cache, m_aw_cache, s_aw_qos, m_aw_qos, s_aw_region, m_aw_region;
    logic        s_aw_user, m_aw_user;
    logic        s_w_valid, s_w_ready, s_w_last, s_w_user;
    logic        m_w_valid, m_w_ready, m_w_last, m_w_user;
    logic [63:0] s_w_data, m_w_data;
    logic [7:0]  s_w_strb, m_w_strb;
    logic        s_b_valid, s_b_ready, s_b_user, m_b_valid, m_b_ready, m_b_user;
    logic [8:0]  s_b_id, m_b_id;
    logic [1:0]  s_b_resp, m_b_resp;
    logic        s_ar_valid, s_ar_ready, s_ar_lock, m_ar_valid, m_ar_ready, m_ar_lock;
    logic [8:0]  s_ar_id, m_ar_id;
    logic [31:0] s_ar_addr, m_ar_addr;
    logic [7:0]  s_ar_len, m_ar_len;
    logic [2:0]  s_ar_size, m_ar_size, s_ar_prot, m_ar_prot;
    logic [1:0]  s_ar_burst, m_ar_burst;
    logic [3:0]  s_ar_cache, m_ar_cache, s_ar_qos, m_ar_qos, s_ar_region, m_ar_region;
    logic        s_ar_user, m_ar_user;
    logic        s_r_valid, s_r_ready, s_r_last, s_r_user;
    logic        m_r_valid, m_r_ready, m_r_last, m_r_user;
    logic [8:0]  s_r_id, m_r_id;
    logic [63:0] s_r_data, m_r_data;
    logic [1:0]  s_r_resp, m_r_resp;

    // AW
    assign s_aw_valid = in_valid[0];
    assign {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock, s_aw_cache,
            s_aw_prot, s_aw_qos, s_aw_region, s_aw_user} = in_pl[0][70:0];
    assign m_aw_ready = out_ready[0];
    assign in_rdy[0]  = s_aw_ready;
    assign out_vld[0] = m_aw_valid;
    assign out_pl[0]  = {9'd0, m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst,
                         m_aw_lock, m_aw_cache, m_aw_prot, m_aw_qos, m_aw_region, m_aw_user};
    // W
    assign s_w_valid = in_valid[1];
    assign {s_w_data, s_w_strb, s_w_last, s_w_user} = in_pl[1][73:0];
    assign m_w_ready  = out_ready[1];
    assign in_rdy[1]  = s_w_ready;
    assign out_vld[1] = m_w_valid;
    assign out_pl[1]  = {6'd0, m_w_data, m_w_strb, m_w_last, m_w_user};
    // B (producer is the master side)
    assign m_b_valid = in_valid[2];
    assign {m_b_id, m_b_resp, m_b_user} = in_pl[2][11:0];
    assign s_b_ready  = out_ready[2];
    assign in_rdy[2]  = m_b_ready;
    assign out_vld[2] = s_b_valid;
    assign out_pl[2]  = {68'd0, s_b_id, s_b_resp, s_b_user};
    // AR
    assign s_ar_valid = in_valid[3];
    assign {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock, s_ar_cache,
            s_ar_prot, s_ar_qos, s_ar_region, s_ar_user} = in_pl[3][70:0];
    assign m_ar_ready = out_ready[3];
    assign in_rdy[3]  = s_ar_ready;
    assign out_vld[3] = m_ar_valid;
    assign out_pl[3]  = {9'd0, m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst,
                         m_ar_lock, m_ar_cache, m_ar_prot, m_ar_qos, m_ar_region, m_ar_user};
    // R (producer is the master side)
    assign m_r_valid = in_valid[4];
    assign {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user} = in_pl[4][76:0];
    assign s_r_ready  = out_ready[4];
    assign in_rdy[4]  = m_r_ready;
    assign out_vld[4] = s_r_valid;
    assign out_pl[4]  = {3'd0, s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user};

    nasti_slice #(
        .ID_WIDTH(9), .ADDR_WIDTH(32), .DATA_WIDTH(64), .USER_WIDTH(1),
        .AW_DEPTH(AW_D), .W_DEPTH(W_D), .B_DEPTH(B_D), .AR_DEPTH(AR_D), .R_DEPTH(R_D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id),
        .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
        .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock), .s_aw_cache(s_aw_cache),
        .s_aw_prot(s_aw_prot), .s_aw_qos(s_aw_qos), .s_aw_region(s_aw_region),
        .s_aw_user(s_aw_user),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
        .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_w_user(s_w_user),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id),
        .s_b_resp(s_b_resp), .s_b_user(s_b_user),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
        .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
        .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock), .s_ar_cache(s_ar_cache),
        .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos), .s_ar_region(s_ar_region),
        .s_ar_user(s_ar_user),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_user(s_r_user),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id),
        .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
        .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock), .m_aw_cache(m_aw_cache),
        .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos), .m_aw_region(m_aw_region),
        .m_aw_user(m_aw_user),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
        .m_w_strb(m_w_strb), .m_w_last(m_w_last), .m_w_user(m_w_user),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id),
        .m_b_resp(m_b_resp), .m_b_user(m_b_user),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
        .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
        .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock), .m_ar_cache(m_ar_cache),
        .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos), .m_ar_region(m_ar_region),
        .m_ar_user(m_ar_user),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_user(m_r_user),
        .idle(idle)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per channel, a ring of accepted-but-not-delivered beats.
    logic [79:0] mq [5][64];
    int          head [5];
    int          tail [5];

    function automatic logic [79:0] pl_mask(input int c);
        return (80'd1 << PW[c]) - 80'd1;
    endfunction

    function automatic logic [79:0] rand_pl(input int c);
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0] & pl_mask(c);
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 5; c++) begin
            head[c] = 0;
            tail[c] = 0;
        end
    endtask

    // Leaves the bench 1 time unit after the first clock edge following release.
    task automatic do_reset();
        in_valid  = '0;
        out_ready = '0;
        for (int c = 0; c < 5; c++) in_pl[c] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
    endtask

    task automatic test_reset();
        in_valid  = 5'b11111;
        out_ready = 5'b11111;
        for (int c = 0; c < 5; c++) in_pl[c] = rand_pl(c);
        rst_n = 1'b0;
        #1;
        repeat (2) begin
            checks++;
            if ({in_rdy[4], in_rdy[2:0]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ready got %b want 0000", {in_rdy[4], in_rdy[2:0]});
            end
            checks++;
            if ({out_vld[4], out_vld[2:0]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_valid got %b want 0000", {out_vld[4], out_vld[2:0]});
            end
            checks++;
            if (idle !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle got %b want 1", idle);
            end
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_rdy[4], in_rdy[2:0]} !== 4'b0000) begin
            errors++;
            $display("FAIL release_ready_early got %b want 0000", {in_rdy[4], in_rdy[2:0]});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({in_rdy[4], in_rdy[2:0]} !== 4'b1111) begin
            errors++;
            $display("FAIL release_ready got %b want 1111", {in_rdy[4], in_rdy[2:0]});
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL release_idle got %b want 1", idle);
        end
    endtask

    task automatic test_single_aw();
        logic [79:0] beat;
        do_reset();
        beat = {9'd0, 9'h1A, 32'h1000_0040, 8'd3, 3'd3, 2'd1, 1'b0, 4'h3, 3'd2, 4'h5,
                4'h6, 1'b1};
        in_pl[0]     = beat;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (m_aw_valid !== 1'b0 || s_aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL aw_cycle0 got valid=%b ready=%b want 0 1", m_aw_valid, s_aw_ready);
        end
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (m_aw_valid !== 1'b1) begin
            errors++;
            $display("FAIL aw_cycle1_valid got %b want 1", m_aw_valid);
        end
        checks++;
        if (m_aw_id !== 9'h1A || m_aw_addr !== 32'h1000_0040 || m_aw_len !== 8'd3) begin
            errors++;
            $display("FAIL aw_fields got id=%h addr=%h len=%0d want 1a 10000040 3",
                     m_aw_id, m_aw_addr, m_aw_len);
        end
        checks++;
        if (out_pl[0] !== beat) begin
            errors++;
            $display("FAIL aw_payload got %h want %h", out_pl[0], beat);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_aw_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL aw_after got valid=%b idle=%b want 0 1", m_aw_valid, idle);
        end
    endtask

    task automatic test_w_stream();
        do_reset();
        out_ready[1] = 1'b1;
        for (int k = 0; k < 18; k++) begin
            in_valid[1] = (k < 16);
            in_pl[1]    = {6'd0, 64'(k), 8'hFF, (k == 15), 1'b0};
            @(negedge clk);
            if (k < 16) begin
                checks++;
                if (s_w_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL w_ready cyc%0d got %b want 1", k, s_w_ready);
                end
            end
            checks++;
            if (m_w_valid !== (k >= 1 && k <= 16)) begin
                errors++;
                $display("FAIL w_valid cyc%0d got %b want %b", k, m_w_valid,
                         (k >= 1 && k <= 16));
            end
            if (k >= 1 && k <= 16) begin
                checks++;
                if (m_w_data !== 64'(k - 1) || m_w_last !== (k == 16)) begin
                    errors++;
                    $display("FAIL w_beat cyc%0d got data=%0d last=%b want %0d %b",
                             k, m_w_data, m_w_last, k - 1, (k == 16));
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_r_backpressure();
        logic [79:0] sent [4];
        int          acc;
        int          got;
        do_reset();
        acc = 0;
        out_ready[4] = 1'b0;
        in_valid[4]  = 1'b1;
        in_pl[4]     = rand_pl(4);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (m_r_ready !== (k < 4)) begin
                errors++;
                $display("FAIL r_fill_ready cyc%0d got %b want %b", k, m_r_ready, (k < 4));
            end
            if (m_r_ready === 1'b1 && acc < 4) begin
                sent[acc] = in_pl[4];
                acc++;
            end
            @(posedge clk);
            #1;
            if (m_r_ready === 1'b1) in_pl[4] = rand_pl(4);
        end
        checks++;
        if (acc != 4 || s_r_valid !== 1'b1) begin
            errors++;
            $display("FAIL r_fill_count got acc=%0d valid=%b want 4 1", acc, s_r_valid);
        end
        in_valid[4]  = 1'b0;
        out_ready[4] = 1'b1;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (s_r_valid === 1'b1) begin
                checks++;
                if (got >= 4) begin
                    errors++;
                    $display("FAIL r_drain_extra got beat %0d want none", got);
                end else if (out_pl[4] !== sent[got]) begin
                    errors++;
                    $display("FAIL r_drain_beat%0d got %h want %h", got, out_pl[4], sent[got]);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL r_drain_count got %0d want 4", got);
        end
    endtask

    task automatic test_ar_bypass();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            in_valid[3]  = 1'($urandom_range(0, 1));
            out_ready[3] = 1'($urandom_range(0, 1));
            in_pl[3]     = rand_pl(3);
            #1;
            checks++;
            if (s_ar_ready !== out_ready[3] || m_ar_valid !== in_valid[3]) begin
                errors++;
                $display("FAIL ar_bypass_hs got ready=%b valid=%b want %b %b",
                         s_ar_ready, m_ar_valid, out_ready[3], in_valid[3]);
            end
            checks++;
            if (out_pl[3] !== in_pl[3]) begin
                errors++;
                $display("FAIL ar_bypass_payload got %h want %h", out_pl[3], in_pl[3]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_b_half_rate();
        logic [79:0] last_b;
        do_reset();
        last_b = '0;
        in_valid[2]  = 1'b1;
        out_ready[2] = 1'b1;
        in_pl[2]     = rand_pl(2);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (m_b_ready !== (k % 2 == 0) || s_b_valid !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL b_rate cyc%0d got ready=%b valid=%b want %b %b", k, m_b_ready,
                         s_b_valid, (k % 2 == 0), (k % 2 == 1));
            end
            if (k % 2 == 1) begin
                checks++;
                if (out_pl[2] !== last_b) begin
                    errors++;
                    $display("FAIL b_payload cyc%0d got %h want %h", k, out_pl[2], last_b);
                end
            end
            if (k % 2 == 0) last_b = in_pl[2];
            @(posedge clk);
            #1;
            if (k % 2 == 0) in_pl[2] = rand_pl(2);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        in_valid = 5'b10011;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 5; c++) in_pl[c] = rand_pl(c);
            @(posedge clk);
            #1;
        end
        checks++;
        if (m_w_valid !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL mid_fill got w_valid=%b idle=%b want 1 0", m_w_valid, idle);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_w_valid !== 1'b0 || m_aw_valid !== 1'b0 || s_r_valid !== 1'b0 || idle !== 1'b1)
        begin
            errors++;
            $display("FAIL mid_reset got w=%b aw=%b r=%b idle=%b want 0 0 0 1",
                     m_w_valid, m_aw_valid, s_r_valid, idle);
        end
        in_valid  = '0;
        out_ready = 5'b11111;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({out_vld[4], out_vld[2:0]} !== 4'b0000 || idle !== 1'b1) begin
                errors++;
                $display("FAIL mid_stale cyc%0d got valids=%b idle=%b want 0000 1", k,
                         {out_vld[4], out_vld[2:0]}, idle);
            end
            @(posedge clk);
            #1;
        end
        clear_model();
    endtask

    task automatic test_random_stall();
        int          occ [5];
        logic        exp_idle;
        logic [79:0] m;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 5; c++) begin
                in_valid[c]  = ($urandom_range(0, 99) < 60);
                out_ready[c] = ($urandom_range(0, 99) < 55);
                in_pl[c]     = rand_pl(c);
            end
            @(negedge clk);
            exp_idle = 1'b1;
            for (int c = 0; c < 5; c++) begin
                occ[c] = tail[c] - head[c];
                if (occ[c] != 0) exp_idle = 1'b0;
            end
            checks++;
            if (idle !== exp_idle) begin
                errors++;
                $display("FAIL rnd_idle cyc%0d got %b want %b", n, idle, exp_idle);
            end
            for (int c = 0; c < 5; c++) begin
                m = pl_mask(c);
                if (DEP[c] == 0) begin
                    checks++;
                    if (in_rdy[c] !== out_ready[c] || out_vld[c] !== in_valid[c]) begin
                        errors++;
                        $display("FAIL rnd_bypass ch%0d cyc%0d got rdy=%b vld=%b want %b %b",
                                 c, n, in_rdy[c], out_vld[c], out_ready[c], in_valid[c]);
                    end
                    if (in_valid[c]) begin
                        checks++;
                        if ((out_pl[c] & m) !== in_pl[c]) begin
                            errors++;
                            $display("FAIL rnd_bypass_pl ch%0d cyc%0d got %h want %h", c, n,
                                     out_pl[c] & m, in_pl[c]);
                        end
                    end
                end else begin
                    checks++;
                    if (in_rdy[c] !== (occ[c] < DEP[c])) begin
                        errors++;
                        $display("FAIL rnd_ready ch%0d cyc%0d got %b want %b", c, n,
                                 in_rdy[c], (occ[c] < DEP[c]));
                    end
                    checks++;
                    if (out_vld[c] !== (occ[c] > 0)) begin
                        errors++;
                        $display("FAIL rnd_valid ch%0d cyc%0d got %b want %b", c, n,
                                 out_vld[c], (occ[c] > 0));
                    end
                    if (occ[c] > 0) begin
                        checks++;
                        if ((out_pl[c] & m) !== mq[c][head[c] % 64]) begin
                            errors++;
                            $display("FAIL rnd_payload ch%0d cyc%0d got %h want %h", c, n,
                                     out_pl[c] & m, mq[c][head[c] % 64]);
                        end
                        if (out_ready[c]) head[c]++;
                    end
                    if (in_valid[c] && occ[c] < DEP[c]) begin
                        mq[c][tail[c] % 64] = in_pl[c];
                        tail[c]++;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int c = 0; c < 5; c++) in_pl[c] = '0;
        clear_model();
        test_reset();
        test_single_aw();
        test_w_stream();
        test_r_backpressure();
        test_ar_bypass();
        test_b_half_rate();
        test_reset_mid_burst();
        test_random_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
